// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the datapath control FSM and alu_seq.
//   start, op, inputa, inputb  : request (master -> slave), captured when ready=1
//   ready                      : slave can accept a request this cycle
//   done                       : one-cycle completion pulse
//   out, branch                : registered result and branch decision
//   zero, carry, negative      : registered flags
interface alu_seq_if #(
    parameter int W   = 8,
    parameter int OPS = 4
);
    logic           start;
    logic [OPS-1:0] op;
    logic [W-1:0]   inputa;
    logic [W-1:0]   inputb;
    logic           ready;
    logic           done;
    logic [W-1:0]   out;
    logic           branch;
    logic           zero;
    logic           carry;
    logic           negative;

    modport master (
        output start, op, inputa, inputb,
        input  ready, done, out, branch, zero, carry, negative
    );

    modport slave (
        input  start, op, inputa, inputb,
        output ready, done, out, branch, zero, carry, negative
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Most ops complete on the accept edge; variable
// shifts step one bit per clock and MUL runs a W-step shift-add.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if slave (request, ready, done, result, flags)
//
// state | meaning
// IDLE  | ready; single-cycle ops complete on the accept edge
// RUN   | iterating a shift or multiply, cnt steps remain
module alu_seq #(
    parameter int W   = 8,
    parameter int OPS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int              CNTW  = $clog2(W) + 1;
    localparam logic [CNTW-1:0] W_CNT = CNTW'(W);

    localparam logic [OPS-1:0] OP_ADD = OPS'(0);
    localparam logic [OPS-1:0] OP_SUB = OPS'(1);
    localparam logic [OPS-1:0] OP_AND = OPS'(2);
    localparam logic [OPS-1:0] OP_OR  = OPS'(3);
    localparam logic [OPS-1:0] OP_XOR = OPS'(4);
    localparam logic [OPS-1:0] OP_LSH = OPS'(5);
    localparam logic [OPS-1:0] OP_RSH = OPS'(6);
    localparam logic [OPS-1:0] OP_MUL = OPS'(7);
    localparam logic [OPS-1:0] OP_GEQ = OPS'(8);
    localparam logic [OPS-1:0] OP_EQ  = OPS'(9);
    localparam logic [OPS-1:0] OP_NEQ = OPS'(10);
    localparam logic [OPS-1:0] OP_BNZ = OPS'(11);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt;
    logic [OPS-1:0]  op_r;
    logic [W-1:0]    acc;      // shift value or running product
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplier;

    logic            ready, accept, last_step;
    logic [CNTW-1:0] amt;
    logic            is_shift, multi;
    logic [W:0]      sum;
    logic [W-1:0]    sc_out;
    logic            sc_carry, sc_branch;
    logic [W-1:0]    step_acc;
    logic            step_bit;

    logic [W-1:0]    out_r;
    logic            done_r, branch_r, zero_r, carry_r, negative_r;

    // Request decode and single-cycle results, straight from the operands.
    always_comb begin
        amt = bus.inputb[CNTW-1:0];
        if (amt > W_CNT)
            amt = W_CNT;
        is_shift  = (bus.op == OP_LSH) || (bus.op == OP_RSH);
        multi     = (bus.op == OP_MUL) || (is_shift && (amt != '0));
        sum       = {1'b0, bus.inputa} + {1'b0, bus.inputb};
        sc_out    = '0;
        sc_carry  = 1'b0;
        sc_branch = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_out   = sum[W-1:0];
                sc_carry = sum[W];
            end
            OP_SUB: begin
                sc_out   = bus.inputa + ~bus.inputb + W'(1);
                sc_carry = (bus.inputa < bus.inputb);
            end
            OP_AND:  sc_out = bus.inputa & bus.inputb;
            OP_OR:   sc_out = bus.inputa | bus.inputb;
            OP_XOR:  sc_out = bus.inputa ^ bus.inputb;
            OP_LSH,
            OP_RSH:  sc_out = bus.inputa;   // only reached with amt=0
            OP_GEQ:  sc_out = {{(W-1){1'b0}}, (bus.inputa >= bus.inputb)};
            OP_EQ:   sc_out = {{(W-1){1'b0}}, (bus.inputa == bus.inputb)};
            OP_NEQ:  sc_out = {{(W-1){1'b0}}, (bus.inputa != bus.inputb)};
            OP_BNZ:  sc_branch = (bus.inputa != '0);
            default: sc_out = '0;
        endcase
    end

    // One iteration of the running op.
    always_comb begin
        step_acc = acc;
        step_bit = 1'b0;
        case (op_r)
            OP_LSH: begin
                step_acc = {acc[W-2:0], 1'b0};
                step_bit = acc[W-1];
            end
            OP_RSH: begin
                step_acc = {1'b0, acc[W-1:1]};
                step_bit = acc[0];
            end
            default: step_acc = mplier[0] ? (acc + mcand) : acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.start;
                if (accept && multi)
                    state_nxt = RUN;
            end
            RUN: begin
                if (cnt == CNTW'(1)) begin
                    last_step = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            op_r       <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            out_r      <= '0;
            done_r     <= 1'b0;
            branch_r   <= 1'b0;
            zero_r     <= 1'b0;
            carry_r    <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                op_r <= bus.op;
                if (multi) begin
                    cnt    <= (bus.op == OP_MUL) ? W_CNT : amt;
                    acc    <= (bus.op == OP_MUL) ? '0 : bus.inputa;
                    mcand  <= bus.inputa;
                    mplier <= bus.inputb;
                end else begin
                    out_r      <= sc_out;
                    carry_r    <= sc_carry;
                    branch_r   <= sc_branch;
                    zero_r     <= (sc_out == '0);
                    negative_r <= sc_out[W-1];
                    done_r     <= 1'b1;
                end
            end else if (state == RUN) begin
                cnt    <= cnt - CNTW'(1);
                acc    <= step_acc;
                mcand  <= {mcand[W-2:0], 1'b0};
                mplier <= {1'b0, mplier[W-1:1]};
                // Visible result only moves on the final step.
                if (last_step) begin
                    out_r      <= step_acc;
                    carry_r    <= step_bit;
                    branch_r   <= 1'b0;
                    zero_r     <= (step_acc == '0);
                    negative_r <= step_acc[W-1];
                    done_r     <= 1'b1;
                end
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.done     = done_r;
    assign bus.out      = out_r;
    assign bus.branch   = branch_r;
    assign bus.zero     = zero_r;
    assign bus.carry    = carry_r;
    assign bus.negative = negative_r;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    typedef struct packed {
        logic [7:0] out;
        logic       branch;
        logic       zero;
        logic       carry;
        logic       negative;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    alu_seq_if #(.W(8), .OPS(4)) bus ();

    alu_seq #(.W(8), .OPS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic [7:0] o, input logic b, input logic z,
                                input logic c, input logic n);
        res_t r;
        r.out = o; r.branch = b; r.zero = z; r.carry = c; r.negative = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        res_t got, e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            got = mk(bus.out, bus.branch, bus.zero, bus.carry, bus.negative);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got out=0x%0h with no request pending", got.out);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result: got out=%h br=%b z=%b c=%b n=%b expected out=%h br=%b z=%b c=%b n=%b",
                             got.out, got.branch, got.zero, got.carry, got.negative,
                             e.out, e.branch, e.zero, e.carry, e.negative);
                end
            end
        end
    end

    // Issue one request, then count cycles to done and cycles with ready low.
    // poke: pulse an ADD start and scramble operands mid-run (must be ignored).
    task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input res_t e, input int k, input bit poke);
        int n, low;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.inputa = a; bus.inputb = b;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0; low = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ready !== 1'b1) low++;
            if (poke && n == 3) begin
                bus.start = 1'b1; bus.op = 4'd0; bus.inputa = 8'h11; bus.inputb = 8'h22;
            end else if (poke && n == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
        end
        chk({name, "_latency"}, 16'(n), 16'(k + 1));
        chk({name, "_ready_low"}, 16'(low), 16'(k));
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.op = '0; bus.inputa = '0; bus.inputb = '0;
        rst_n = 1'b0;
        #12;
        chk("reset_out", 16'(bus.out), 16'h0);
        chk("reset_flags", 16'({bus.done, bus.branch, bus.zero, bus.carry, bus.negative}), 16'h0);
        chk("reset_ready", 16'(bus.ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_carry", 4'd0, 8'hFF, 8'h01, mk(8'h00, 0, 1, 1, 0), 0, 0);
        issue("sub_borrow", 4'd1, 8'h03, 8'h05, mk(8'hFE, 0, 0, 1, 1), 0, 0);
        issue("and", 4'd2, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0), 0, 0);
        issue("or", 4'd3, 8'hF0, 8'h0C, mk(8'hFC, 0, 0, 0, 1), 0, 0);
        issue("xor", 4'd4, 8'hAA, 8'hAA, mk(8'h00, 0, 1, 0, 0), 0, 0);
        issue("geq_lt", 4'd8, 8'h04, 8'h05, mk(8'h00, 0, 1, 0, 0), 0, 0);
        issue("neq", 4'd10, 8'h03, 8'h04, mk(8'h01, 0, 0, 0, 0), 0, 0);
        issue("nop", 4'd15, 8'hFF, 8'hFF, mk(8'h00, 0, 1, 0, 0), 0, 0);
        issue("mul_ff", 4'd7, 8'hFF, 8'hFF, mk(8'h01, 0, 0, 0, 0), 8, 0);
        issue("mul_poke", 4'd7, 8'd13, 8'd11, mk(8'h8F, 0, 0, 0, 1), 8, 1);
        repeat (3) @(negedge clk);
        chk("mul_held_out", 16'(bus.out), 16'h8F);

        // Reset on the 4th cycle of a MUL: no done, outputs cleared at once.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd7; bus.inputa = 8'h0F; bus.inputb = 8'h0F;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b1; bus.op = 4'd0;
        #1;
        chk("rst_mid_out", 16'(bus.out), 16'h0);
        chk("rst_mid_flags", 16'({bus.done, bus.branch, bus.zero, bus.carry, bus.negative}), 16'h0);
        chk("rst_mid_ready", 16'(bus.ready), 16'h1);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 16'(bus.done), 16'h0);
        issue("add_after_rst", 4'd0, 8'h02, 8'h02, mk(8'h04, 0, 0, 0, 0), 0, 0);

        issue("lsh3", 4'd5, 8'h81, 8'h03, mk(8'h08, 0, 0, 0, 0), 3, 0);
        issue("rsh0", 4'd6, 8'h81, 8'h00, mk(8'h81, 0, 0, 0, 1), 0, 0);
        issue("lsh12", 4'd5, 8'hFF, 8'h0C, mk(8'h00, 0, 1, 1, 0), 8, 0);
        issue("rsh2", 4'd6, 8'h83, 8'h02, mk(8'h20, 0, 0, 1, 0), 2, 0);

        // Back-to-back single-cycle ops: BNZ 0, BNZ 0x10, EQ 5A/5A.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd11; bus.inputa = 8'h00; bus.inputb = 8'h00;
        sb.push_back(mk(8'h00, 0, 1, 0, 0));
        @(negedge clk);
        chk("b2b_done1", 16'(bus.done), 16'h1);
        bus.op = 4'd11; bus.inputa = 8'h10;
        sb.push_back(mk(8'h00, 1, 1, 0, 0));
        @(negedge clk);
        chk("b2b_done2", 16'(bus.done), 16'h1);
        bus.op = 4'd9; bus.inputa = 8'h5A; bus.inputb = 8'h5A;
        sb.push_back(mk(8'h01, 0, 0, 0, 0));
        @(negedge clk);
        chk("b2b_done3", 16'(bus.done), 16'h1);
        chk("b2b_ready", 16'(bus.ready), 16'h1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_done_end", 16'(bus.done), 16'h0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
